// File: rtl/uart_bus_pkg.sv
// Register map and FSM encoding shared by the uart bus master and its helpers.
package uart_bus_pkg;
    localparam logic [2:0] DATA_ADDR   = 3'd0;
    localparam logic [2:0] STATUS_ADDR = 3'd1;
    localparam int         RX_RDY_BIT  = 0;
    localparam int         TX_BUSY_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_STATUS = 3'd1,
        ST_RD_DATA   = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_GAP       = 3'd4
    } state_t;
endpackage

// File: rtl/uart_bus_master_bus_phase_gen.sv
// Free-running phi2 generator; the strobe marks the last clock of the phi2-high
// phase, which is both where read data is sampled and where the next bus cycle begins.
module bus_phase_gen #(
    parameter int HALF_CYCLE = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_phi2,
    output logic o_cycle_start,
    output logic o_sample
);
    localparam int              CNT_W    = (HALF_CYCLE > 1) ? $clog2(HALF_CYCLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALF_CYCLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phi2_q, phi2_d;
    logic             wrap;

    // Down-counter per phase; terminal count flips phi2 and reloads.
    always_comb begin
        wrap   = (cnt_q == '0);
        cnt_d  = wrap ? CNT_LOAD : cnt_q - 1'b1;
        phi2_d = wrap ? ~phi2_q : phi2_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= CNT_LOAD;
            phi2_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            phi2_q <= phi2_d;
        end
    end

    assign o_phi2        = phi2_q;
    assign o_cycle_start = wrap && phi2_q;
    assign o_sample      = wrap && phi2_q;
endmodule

// File: rtl/uart_bus_master.sv
// 6502-style bus initiator that polls a uart, drains RX bytes into a valid/ready
// stream and writes bytes from a valid/ready stream into the uart DATA register.
//
// state        | meaning
// ST_IDLE      | out of reset, waiting for the first bus cycle
// ST_RD_STATUS | reading STATUS; next cycle chosen from it
// ST_RD_DATA   | reading an RX byte into the RX holding reg
// ST_WR_DATA   | writing the TX holding reg to the uart
// ST_GAP       | idle bus cycle(s) after a poll with no transfer
module uart_bus_master #(
    parameter int         HALF_CYCLE  = 2,
    parameter logic [2:0] DATA_ADDR   = uart_bus_pkg::DATA_ADDR,
    parameter logic [2:0] STATUS_ADDR = uart_bus_pkg::STATUS_ADDR,
    parameter int         RX_RDY_BIT  = uart_bus_pkg::RX_RDY_BIT,
    parameter int         TX_BUSY_BIT = uart_bus_pkg::TX_BUSY_BIT,
    parameter int         POLL_GAP    = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic       o_phi2,
    output logic [2:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_rw,
    output logic       o_en,
    input  logic [7:0] i_data,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    input  logic       i_rx_ready
);
    import uart_bus_pkg::*;

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    logic             cycle_start, sample;
    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             en_q, en_d, rw_q, rw_d;
    logic [2:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       tx_byte_q, tx_byte_d, rx_byte_q, rx_byte_d;
    logic             tx_full_q, tx_full_d, rx_valid_q, rx_valid_d;
    logic             rx_rdy, tx_busy;

    bus_phase_gen #(.HALF_CYCLE(HALF_CYCLE)) u_phase (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .o_phi2       (o_phi2),
        .o_cycle_start(cycle_start),
        .o_sample     (sample)
    );

    assign rx_rdy  = i_data[RX_RDY_BIT];
    assign tx_busy = i_data[TX_BUSY_BIT];

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        en_d       = en_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_byte_d  = tx_byte_q;
        tx_full_d  = tx_full_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;

        if (i_tx_valid && !tx_full_q) begin
            tx_byte_d = i_tx_byte;
            tx_full_d = 1'b1;
        end
        if (rx_valid_q && i_rx_ready) rx_valid_d = 1'b0;

        if (sample && state_q == ST_RD_DATA) begin
            rx_byte_d  = i_data;
            rx_valid_d = 1'b1;
        end
        if (sample && state_q == ST_WR_DATA) tx_full_d = 1'b0;

        if (cycle_start) begin
            case (state_q)
                ST_RD_STATUS: begin
                    // RX wins so a full uart receiver is never starved by TX traffic.
                    if (rx_rdy && !rx_valid_q)        state_d = ST_RD_DATA;
                    else if (!tx_busy && tx_full_q)   state_d = ST_WR_DATA;
                    else if (POLL_GAP == 0)           state_d = ST_RD_STATUS;
                    else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(POLL_GAP - 1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) state_d = ST_RD_STATUS;
                    else             gap_d   = gap_q - 1'b1;
                end
                default: state_d = ST_RD_STATUS;
            endcase

            case (state_d)
                ST_RD_STATUS: begin en_d = 1'b1; rw_d = 1'b1; addr_d = STATUS_ADDR; end
                ST_RD_DATA:   begin en_d = 1'b1; rw_d = 1'b1; addr_d = DATA_ADDR;   end
                ST_WR_DATA: begin
                    en_d   = 1'b1;
                    rw_d   = 1'b0;
                    addr_d = DATA_ADDR;
                    data_d = tx_byte_q;
                end
                default: begin en_d = 1'b0; rw_d = 1'b1; end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            gap_q      <= '0;
            en_q       <= 1'b0;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            tx_byte_q  <= '0;
            tx_full_q  <= 1'b0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            en_q       <= en_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_byte_q  <= tx_byte_d;
            tx_full_q  <= tx_full_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign o_en       = en_q;
    assign o_rw       = rw_q;
    assign o_addr     = addr_q;
    assign o_data     = data_q;
    assign o_tx_ready = ~tx_full_q;
    assign o_rx_byte  = rx_byte_q;
    assign o_rx_valid = rx_valid_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master against a two-register uart model
// (STATUS at address 1, DATA at address 0) that commits writes on a full phi2-high phase.
`timescale 1ns/1ps
module tb_uart_bus_master;
    localparam int HC = 2;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       o_phi2, o_rw, o_en, o_tx_ready, o_rx_valid;
    logic [2:0] o_addr;
    logic [7:0] o_data, i_data, o_rx_byte;
    logic [7:0] i_tx_byte = 8'h00;
    logic       i_tx_valid = 1'b0;
    logic       i_rx_ready = 1'b0;

    logic [7:0] status_reg = 8'h00;
    logic [7:0] data_reg = 8'h00;

    typedef struct packed {
        logic        en;
        logic        rw;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [31:0] clk;
    } cyc_t;
    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    cyc_t        cyc_log[$];
    wr_t         writes[$];
    logic [31:0] clk_n = 0;
    logic [7:0]  hi_run = 0;
    logic        p_phi2 = 1'b0, p_en = 1'b0, p_rw = 1'b1;
    logic [2:0]  p_addr = 3'd0;
    logic [7:0]  p_data = 8'h00;

    int checks = 0;
    int errors = 0;

    uart_bus_master #(.HALF_CYCLE(HC)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .o_phi2    (o_phi2),
        .o_addr    (o_addr),
        .o_data    (o_data),
        .o_rw      (o_rw),
        .o_en      (o_en),
        .i_data    (i_data),
        .i_tx_byte (i_tx_byte),
        .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready),
        .o_rx_byte (o_rx_byte),
        .o_rx_valid(o_rx_valid),
        .i_rx_ready(i_rx_ready)
    );

    always #5 i_clk = ~i_clk;

    assign i_data = (o_addr == 3'd1) ? status_reg : data_reg;

    always @(posedge i_clk) begin
        clk_n  <= clk_n + 1;
        p_phi2 <= o_phi2;
        p_en   <= o_en;
        p_rw   <= o_rw;
        p_addr <= o_addr;
        p_data <= o_data;
        hi_run <= o_phi2 ? hi_run + 8'd1 : 8'd0;
    end

    // Uart model: a write lands only if phi2 stayed high for a full phase.
    always @(negedge i_clk) begin
        if (p_phi2 && !o_phi2) begin
            if (hi_run == 8'(HC) && p_en && !p_rw) writes.push_back('{p_addr, p_data});
            if (!i_reset) cyc_log.push_back('{o_en, o_rw, o_addr, o_data, clk_n});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] t0;
        i_reset = 1'b1;
        step(3);
        checks++; if (o_en !== 1'b0)       begin errors++; $display("FAIL reset_en got %b want 0", o_en); end
        checks++; if (o_rw !== 1'b1)       begin errors++; $display("FAIL reset_rw got %b want 1", o_rw); end
        checks++; if (o_phi2 !== 1'b0)     begin errors++; $display("FAIL reset_phi2 got %b want 0", o_phi2); end
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", o_rx_valid); end
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", o_tx_ready); end
        checks++; if (o_addr !== 3'd0)     begin errors++; $display("FAIL reset_addr got %0d want 0", o_addr); end
        checks++; if (o_data !== 8'h00)    begin errors++; $display("FAIL reset_data got %h want 00", o_data); end
        checks++; if (o_rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", o_rx_byte); end
        i_reset = 1'b0;
        t0 = clk_n;
        cyc_log.delete();
        for (int i = 0; i < 20 && o_en !== 1'b1; i++) step(1);
        checks++; if (o_en !== 1'b1) begin errors++; $display("FAIL first_cycle_timeout en got %b want 1", o_en); end
        checks++; if (clk_n - t0 !== 32'd4) begin errors++; $display("FAIL first_cycle_clocks got %0d want 4", clk_n - t0); end
        checks++;
        if (o_addr !== 3'd1 || o_rw !== 1'b1 || o_phi2 !== 1'b0)
            begin errors++; $display("FAIL first_cycle_status addr=%0d rw=%b phi2=%b want addr=1 rw=1 phi2=0", o_addr, o_rw, o_phi2); end
    endtask

    task automatic test_poll_gap;
        int bad;
        cyc_log.delete();
        step(24);
        checks++; if (cyc_log.size() !== 6) begin errors++; $display("FAIL poll_cycles got %0d want 6", cyc_log.size()); end
        bad = 0;
        foreach (cyc_log[i]) begin
            if (cyc_log[i].en !== ((i % 2) == 1) || cyc_log[i].rw !== 1'b1 || cyc_log[i].addr !== 3'd1)
                bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL poll_gap_pattern got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_rx;
        logic [31:0] t0;
        int rd;
        data_reg   = 8'hA5;
        status_reg = 8'h01;
        t0 = clk_n;
        cyc_log.delete();
        for (int i = 0; i < 40 && o_rx_valid !== 1'b1; i++) step(1);
        checks++; if (o_rx_valid !== 1'b1) begin errors++; $display("FAIL rx_valid_timeout got %b want 1", o_rx_valid); end
        checks++; if (clk_n - t0 !== 32'd8) begin errors++; $display("FAIL rx_latency got %0d want 8", clk_n - t0); end
        checks++; if (o_rx_byte !== 8'hA5) begin errors++; $display("FAIL rx_byte got %h want a5", o_rx_byte); end
        checks++;
        if (cyc_log.size() < 1 || cyc_log[0].en !== 1'b1 || cyc_log[0].rw !== 1'b1 || cyc_log[0].addr !== 3'd0 || cyc_log[0].clk !== t0 + 4)
            begin errors++; $display("FAIL rx_rd_data_cycle got size=%0d want RD_DATA at clock %0d", cyc_log.size(), t0 + 4); end
        data_reg = 8'h5A;
        step(20);
        rd = 0;
        foreach (cyc_log[i]) if (cyc_log[i].en && cyc_log[i].rw && cyc_log[i].addr == 3'd0) rd++;
        checks++; if (rd != 1) begin errors++; $display("FAIL rx_hold_no_reread got %0d reads want 1", rd); end
        checks++;
        if (o_rx_valid !== 1'b1 || o_rx_byte !== 8'hA5)
            begin errors++; $display("FAIL rx_hold got valid=%b byte=%h want 1 a5", o_rx_valid, o_rx_byte); end
        status_reg = 8'h00;
        i_rx_ready = 1'b1;
        step(1);
        i_rx_ready = 1'b0;
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL rx_consume got %b want 0", o_rx_valid); end
    endtask

    task automatic test_tx;
        int wr_idx;
        status_reg = 8'h00;
        cyc_log.delete();
        writes.delete();
        i_tx_byte  = 8'h3C;
        i_tx_valid = 1'b1;
        step(1);
        checks++; if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_after_load got %b want 0", o_tx_ready); end
        i_tx_byte = 8'hFF;
        step(1);
        i_tx_valid = 1'b0;
        i_tx_byte  = 8'h00;
        for (int i = 0; i < 60 && o_tx_ready !== 1'b1; i++) step(1);
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_timeout got %b want 1", o_tx_ready); end
        wr_idx = -1;
        foreach (cyc_log[i]) if (wr_idx < 0 && cyc_log[i].en && !cyc_log[i].rw) wr_idx = i;
        checks++;
        if (wr_idx < 0 || cyc_log[wr_idx].addr !== 3'd0 || cyc_log[wr_idx].data !== 8'h3C)
            begin errors++; $display("FAIL tx_write_cycle got idx=%0d want addr=0 data=3c", wr_idx); end
        checks++;
        if (wr_idx < 0 || clk_n !== cyc_log[wr_idx].clk + 4)
            begin errors++; $display("FAIL tx_ready_at_cycle_end got clock %0d want write start + 4", clk_n); end
        checks++;
        if (writes.size() != 1 || writes[0].addr !== 3'd0 || writes[0].data !== 8'h3C)
            begin errors++; $display("FAIL tx_model_write got count=%0d want 1 write of 3c", writes.size()); end
    endtask

    task automatic test_priority;
        int rd_idx, wr_idx;
        cyc_log.delete();
        writes.delete();
        data_reg   = 8'h42;
        status_reg = 8'h01;
        i_tx_byte  = 8'h81;
        i_tx_valid = 1'b1;
        step(1);
        i_tx_valid = 1'b0;
        for (int i = 0; i < 80 && o_tx_ready !== 1'b1; i++) step(1);
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL prio_tx_timeout got %b want 1", o_tx_ready); end
        rd_idx = -1;
        wr_idx = -1;
        foreach (cyc_log[i]) begin
            if (rd_idx < 0 && cyc_log[i].en && cyc_log[i].rw && cyc_log[i].addr == 3'd0) rd_idx = i;
            if (wr_idx < 0 && cyc_log[i].en && !cyc_log[i].rw) wr_idx = i;
        end
        checks++;
        if (rd_idx < 0 || wr_idx != rd_idx + 2)
            begin errors++; $display("FAIL prio_order got rd=%0d wr=%0d want wr=rd+2", rd_idx, wr_idx); end
        checks++;
        if (o_rx_valid !== 1'b1 || o_rx_byte !== 8'h42)
            begin errors++; $display("FAIL prio_rx got valid=%b byte=%h want 1 42", o_rx_valid, o_rx_byte); end
        checks++;
        if (writes.size() != 1 || writes[0].data !== 8'h81)
            begin errors++; $display("FAIL prio_write got count=%0d want 1 write of 81", writes.size()); end
    endtask

    task automatic test_tx_stall;
        int st, gp, other;
        writes.delete();
        status_reg = 8'h03;
        i_tx_byte  = 8'h99;
        i_tx_valid = 1'b1;
        step(1);
        i_tx_valid = 1'b0;
        cyc_log.delete();
        step(48);
        st = 0; gp = 0; other = 0;
        foreach (cyc_log[i]) begin
            if (!cyc_log[i].en) gp++;
            else if (cyc_log[i].rw && cyc_log[i].addr == 3'd1) st++;
            else other++;
        end
        checks++;
        if (st != 6 || gp != 6 || other != 0)
            begin errors++; $display("FAIL stall_polls got status=%0d gap=%0d other=%0d want 6 6 0", st, gp, other); end
        checks++;
        if (writes.size() != 0 || o_tx_ready !== 1'b0)
            begin errors++; $display("FAIL stall_no_write got writes=%0d ready=%b want 0 0", writes.size(), o_tx_ready); end
        status_reg = 8'h01;
        for (int i = 0; i < 40 && o_tx_ready !== 1'b1; i++) step(1);
        checks++;
        if (o_tx_ready !== 1'b1 || writes.size() != 1 || writes[0].data !== 8'h99)
            begin errors++; $display("FAIL stall_release got ready=%b writes=%0d want 1 1 (99)", o_tx_ready, writes.size()); end
        status_reg = 8'h00;
        i_rx_ready = 1'b1;
        step(1);
        i_rx_ready = 1'b0;
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL stall_rx_consume got %b want 0", o_rx_valid); end
    endtask

    task automatic test_reset_mid_write;
        status_reg = 8'h00;
        writes.delete();
        i_tx_byte  = 8'hC3;
        i_tx_valid = 1'b1;
        step(1);
        i_tx_valid = 1'b0;
        for (int i = 0; i < 40 && !(o_en === 1'b1 && o_rw === 1'b0); i++) step(1);
        checks++;
        if (o_en !== 1'b1 || o_rw !== 1'b0 || o_data !== 8'hC3)
            begin errors++; $display("FAIL rst_wr_start got en=%b rw=%b data=%h want 1 0 c3", o_en, o_rw, o_data); end
        for (int i = 0; i < 8 && o_phi2 !== 1'b1; i++) step(1);
        i_reset = 1'b1;
        step(1);
        checks++;
        if (o_en !== 1'b0 || o_phi2 !== 1'b0)
            begin errors++; $display("FAIL rst_same_edge got en=%b phi2=%b want 0 0", o_en, o_phi2); end
        step(2);
        i_reset = 1'b0;
        checks++; if (writes.size() != 0) begin errors++; $display("FAIL rst_no_commit got %0d writes want 0", writes.size()); end
        checks++;
        if (o_tx_ready !== 1'b1 || o_rx_valid !== 1'b0)
            begin errors++; $display("FAIL rst_holding_cleared got ready=%b rx_valid=%b want 1 0", o_tx_ready, o_rx_valid); end
        for (int i = 0; i < 20 && o_en !== 1'b1; i++) step(1);
        checks++;
        if (o_en !== 1'b1 || o_addr !== 3'd1 || o_rw !== 1'b1)
            begin errors++; $display("FAIL rst_recover got en=%b addr=%0d rw=%b want 1 1 1", o_en, o_addr, o_rw); end
    endtask

    initial begin
        test_reset;
        test_poll_gap;
        test_rx;
        test_tx;
        test_priority;
        test_tx_stall;
        test_reset_mid_write;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
